// File: rtl/hyperbus_mem_responder_if.sv
// Word-level HyperBus link between the DDR PHY shim (master side, controller
// facing) and the memory responder (slave side).
interface hyperbus_mem_responder_if;
    logic        cs_n;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic [1:0]  rx_mask;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        rwds_lat;
    logic        busy;

    modport master (
        output cs_n, rx_valid, rx_data, rx_mask,
        input  tx_valid, tx_data, rwds_lat, busy
    );

    modport slave (
        input  cs_n, rx_valid, rx_data, rx_mask,
        output tx_valid, tx_data, rwds_lat, busy
    );
endinterface

// File: rtl/hyperbus_mem_responder.sv
// HyperRAM-style device-side responder working on one 16-bit word per CK.
// Decodes the 48-bit CA phase, applies initial latency and serves CR0 and
// memory reads/writes. Optional macro HYPERBUS_MEM_RESPONDER_WRAP_EN enables
// wrapped bursts (group size from CR0[1:0]); without it all bursts are linear.
module hyperbus_mem_responder #(
    parameter int unsigned AddrWidth = 12,
    parameter logic [15:0] Cr0Reset  = 16'h8F1F,
    parameter logic [31:0] RegAddr   = 32'h0000_0800
) (
    input logic                     clk_i,
    input logic                     rst_i,
    hyperbus_mem_responder_if.slave hb_io
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StCa      = 3'd1;
    localparam logic [2:0] StLatency = 3'd2;
    localparam logic [2:0] StRd      = 3'd3;
    localparam logic [2:0] StWr      = 3'd4;
    localparam logic [2:0] StRegWr   = 3'd5;

    logic [2:0]           state_q, state_d;
    logic                 ca_idx_q, ca_idx_d;       // 0: expecting CA[31:16], 1: CA[15:0]
    logic [31:0]          ca_hi_q, ca_hi_d;         // CA[47:16]
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic                 is_read_q, is_read_d;
    logic                 is_reg_q, is_reg_d;
    logic                 is_linear_q, is_linear_d;
    logic                 reg_hit_q, reg_hit_d;
    logic                 reg_done_q, reg_done_d;
    logic [4:0]           lat_q, lat_d;
    logic [15:0]          cr0_q, cr0_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [15:0]          tx_data_q, tx_data_d;

    logic [15:0]          mem_q [2**AddrWidth];
    logic                 mem_we;
    logic [AddrWidth-1:0] addr_inc;
    logic [15:0]          rd_word;
    logic [31:0]          start_addr;

    // Initial latency in CK cycles: tLAT from CR0[7:4], doubled by CR0[3].
    function automatic logic [4:0] lat_cycles(logic [4:0] cr0_lat);
        logic [2:0] t;
        unique case (cr0_lat[4:1])
            4'h0:    t = 3'd5;
            4'h1:    t = 3'd6;
            4'hE:    t = 3'd3;
            4'hF:    t = 3'd4;
            default: t = 3'd6;
        endcase
        return cr0_lat[0] ? {1'b0, t, 1'b0} : {2'b00, t};
    endfunction

`ifdef HYPERBUS_MEM_RESPONDER_WRAP_EN
    logic [5:0]           grp_mask6;
    logic [AddrWidth-1:0] grp_mask;

    // Wrapped bursts advance only the low bits inside the aligned group.
    always_comb begin
        unique case (cr0_q[1:0])
            2'b00:   grp_mask6 = 6'h3F;
            2'b01:   grp_mask6 = 6'h1F;
            2'b10:   grp_mask6 = 6'h07;
            default: grp_mask6 = 6'h0F;
        endcase
        grp_mask = is_linear_q ? '1 : AddrWidth'(grp_mask6);
        addr_inc = (addr_q & ~grp_mask) | ((addr_q + AddrWidth'(1)) & grp_mask);
    end
`else
    logic unused_linear;
    assign unused_linear = is_linear_q;
    assign addr_inc      = addr_q + AddrWidth'(1);
`endif

    assign start_addr = {ca_hi_q[28:0], hb_io.rx_data[2:0]};
    assign rd_word    = is_reg_q ? (reg_hit_q ? cr0_q : 16'h0000) : mem_q[addr_q];

    assign hb_io.tx_valid = tx_valid_q;
    assign hb_io.tx_data  = tx_data_q;
    assign hb_io.rwds_lat = (state_q == StCa) && cr0_q[3];
    assign hb_io.busy     = (state_q != StIdle);

    // Transaction sequencing; chip select high aborts from any state.
    always_comb begin
        state_d     = state_q;
        ca_idx_d    = ca_idx_q;
        ca_hi_d     = ca_hi_q;
        addr_d      = addr_q;
        is_read_d   = is_read_q;
        is_reg_d    = is_reg_q;
        is_linear_d = is_linear_q;
        reg_hit_d   = reg_hit_q;
        reg_done_d  = reg_done_q;
        lat_d       = lat_q;
        cr0_d       = cr0_q;
        tx_valid_d  = 1'b0;
        tx_data_d   = tx_data_q;
        mem_we      = 1'b0;

        if (hb_io.cs_n) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (hb_io.rx_valid) begin
                        ca_hi_d[31:16] = hb_io.rx_data;
                        ca_idx_d       = 1'b0;
                        state_d        = StCa;
                    end
                end
                StCa: begin
                    if (hb_io.rx_valid) begin
                        if (!ca_idx_q) begin
                            ca_hi_d[15:0] = hb_io.rx_data;
                            ca_idx_d      = 1'b1;
                        end else begin
                            is_read_d   = ca_hi_q[31];
                            is_reg_d    = ca_hi_q[30];
                            is_linear_d = ca_hi_q[29];
                            addr_d      = start_addr[AddrWidth-1:0];
                            reg_hit_d   = (start_addr == RegAddr);
                            reg_done_d  = 1'b0;
                            lat_d       = lat_cycles(cr0_q[7:3]);
                            // Register writes carry no latency.
                            state_d     = (!ca_hi_q[31] && ca_hi_q[30]) ? StRegWr : StLatency;
                        end
                    end
                end
                StLatency: begin
                    if (lat_q == 5'd1) begin
                        if (is_read_q) begin
                            // Prefetch the first word so RD starts without a bubble.
                            state_d    = StRd;
                            tx_valid_d = 1'b1;
                            tx_data_d  = rd_word;
                            addr_d     = addr_inc;
                        end else begin
                            state_d = StWr;
                        end
                    end else begin
                        lat_d = lat_q - 5'd1;
                    end
                end
                StRd: begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = rd_word;
                    addr_d     = addr_inc;
                end
                StWr: begin
                    if (hb_io.rx_valid) begin
                        mem_we = 1'b1;
                        addr_d = addr_inc;
                    end
                end
                StRegWr: begin
                    if (hb_io.rx_valid && !reg_done_q) begin
                        reg_done_d = 1'b1;
                        if (reg_hit_q) begin
                            cr0_d = hb_io.rx_data;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            ca_idx_q    <= 1'b0;
            ca_hi_q     <= '0;
            addr_q      <= '0;
            is_read_q   <= 1'b0;
            is_reg_q    <= 1'b0;
            is_linear_q <= 1'b0;
            reg_hit_q   <= 1'b0;
            reg_done_q  <= 1'b0;
            lat_q       <= '0;
            cr0_q       <= Cr0Reset;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            ca_idx_q    <= ca_idx_d;
            ca_hi_q     <= ca_hi_d;
            addr_q      <= addr_d;
            is_read_q   <= is_read_d;
            is_reg_q    <= is_reg_d;
            is_linear_q <= is_linear_d;
            reg_hit_q   <= reg_hit_d;
            reg_done_q  <= reg_done_d;
            lat_q       <= lat_d;
            cr0_q       <= cr0_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
        end
    end

    // Byte-masked memory write; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            if (!hb_io.rx_mask[1]) mem_q[addr_q][15:8] <= hb_io.rx_data[15:8];
            if (!hb_io.rx_mask[0]) mem_q[addr_q][7:0]  <= hb_io.rx_data[7:0];
        end
    end

endmodule
